// File: rtl/page_nav_pkg.sv
// Shared types and sizing helpers for the page navigator.
package page_nav_pkg;

  typedef enum logic [1:0] {StOff, StManual, StAuto} state_e;

  localparam int unsigned PAGE_W = 10;
  localparam int unsigned AUTO_W = 29;

  // Bits needed to hold 0..val-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < val) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, counting debouncer and rising-edge strobe for one raw input.
module btn_debounce
  import page_nav_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = clog2(DB_CYCLES);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Level flips only once the synchronised input has disagreed for DB_CYCLES clocks in a row.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/page_navigator.sv
// Page navigator: conditions buttons/switches, runs the OFF/MANUAL/AUTO FSM,
// holds the current page and the auto-advance timer.
module page_navigator
  import page_nav_pkg::*;
#(
  parameter int unsigned NUM_PAGES   = 100,
  parameter int unsigned DB_CYCLES   = 2_000_000,
  parameter int unsigned AUTO_CYCLES = 300_000_000
) (
  input  logic              clk100mhz,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_home,
  input  logic              sw_power,
  input  logic              sw_auto,
  output logic [PAGE_W-1:0] page,
  output logic              ena,
  output logic              page_pulse
);

  // Bit order: next, prev, home, power, auto.
  logic [4:0] raw, lvl, rise;
  assign raw = {sw_auto, sw_power, btn_home, btn_prev, btn_next};

  for (genvar g = 0; g < 5; g++) begin : g_cond
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i  (clk100mhz),
      .rst_ni (rst_n),
      .raw_i  (raw[g]),
      .level_o(lvl[g]),
      .rise_o (rise[g])
    );
  end

  logic unused_cond;
  assign unused_cond = ^{lvl[2:0], rise[4:3]};

  logic press_next, press_prev, press_home, pwr_on, auto_on;
  assign press_next = rise[0];
  assign press_prev = rise[1];
  assign press_home = rise[2];
  assign pwr_on     = lvl[3];
  assign auto_on    = lvl[4];

  state_e              state_q, state_d;
  logic [PAGE_W-1:0]   page_q, page_d, page_inc, page_dec;
  logic [AUTO_W-1:0]   timer_q, timer_d;
  logic                pulse_q, pulse_d;
  logic                active, expire, any_press;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff:    if (pwr_on) state_d = auto_on ? StAuto : StManual;
      StManual: if (auto_on) state_d = StAuto;
      StAuto:   if (!auto_on) state_d = StManual;
      default:  state_d = StOff;
    endcase
    if (!pwr_on) state_d = StOff;
  end

  // Compare against the limits before stepping so nothing ever wraps in PAGE_W bits.
  assign page_inc = (page_q >= PAGE_W'(NUM_PAGES)) ? PAGE_W'(1) : page_q + 1'b1;
  assign page_dec = (page_q <= PAGE_W'(1)) ? PAGE_W'(NUM_PAGES) : page_q - 1'b1;

  assign active    = (state_q != StOff);
  assign expire    = (state_q == StAuto) && (timer_q == AUTO_W'(AUTO_CYCLES - 1));
  assign any_press = active && (press_next || press_prev || press_home);

  always_comb begin
    page_d = page_q;
    if (active) begin
      if (press_home)                    page_d = PAGE_W'(1);
      else if (press_next && press_prev) page_d = page_q;
      else if (press_next)               page_d = page_inc;
      else if (press_prev)               page_d = page_dec;
      else if (expire)                   page_d = page_inc;
    end

    // A press in the expiry cycle consumes the expiry too.
    timer_d = timer_q + 1'b1;
    if (state_q != StAuto || state_d != StAuto || any_press || expire) timer_d = '0;

    pulse_d = (page_d != page_q);
  end

  always_ff @(posedge clk100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      page_q  <= PAGE_W'(1);
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  assign page       = page_q;
  assign ena        = active;
  assign page_pulse = pulse_q;

endmodule

// File: tb/tb_page_navigator.sv
// Scoreboard bench for page_navigator: stimulus pushes expected pages, a monitor checks each pulse.
module tb_page_navigator;

  localparam int unsigned NP = 5;
  localparam int unsigned DB = 4;
  localparam int unsigned AC = 50;

  logic       clk, rst_n;
  logic       btn_next, btn_prev, btn_home, sw_power, sw_auto;
  logic [9:0] page;
  logic       ena, page_pulse;

  page_navigator #(
    .NUM_PAGES  (NP),
    .DB_CYCLES  (DB),
    .AUTO_CYCLES(AC)
  ) dut (
    .clk100mhz (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .btn_home  (btn_home),
    .sw_power  (sw_power),
    .sw_auto   (sw_auto),
    .page      (page),
    .ena       (ena),
    .page_pulse(page_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_q[$];
  int stamps_q[$];

  int m_page = 1;
  bit m_on   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expected page.
  always @(negedge clk) begin
    if (rst_n && page_pulse) begin
      stamps_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected pulse: page %0d at cycle %0d, none expected", page, cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(page) != e) begin
          bad++;
          $display("FAIL pulse page: got %0d expected %0d", page, e);
        end
      end
    end
  end

  // Reference model uses modular arithmetic on pages 1..NP.
  function automatic int nxt(input int p);
    return (p % NP) + 1;
  endfunction
  function automatic int prv(input int p);
    return ((p + NP - 2) % NP) + 1;
  endfunction

  task automatic m_set(input int np);
    if (np != m_page) exp_q.push_back(np);
    m_page = np;
  endtask

  task automatic m_press(input bit n, input bit p, input bit h);
    if (!m_on) return;
    if (h)           m_set(1);
    else if (n && p) m_set(m_page);
    else if (n)      m_set(nxt(m_page));
    else if (p)      m_set(prv(m_page));
  endtask

  task automatic press(input bit n, input bit p, input bit h);
    m_press(n, p, h);
    @(negedge clk);
    btn_next = n; btn_prev = p; btn_home = h;
    repeat (10) @(negedge clk);
    btn_next = 0; btn_prev = 0; btn_home = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string what);
    int k;
    k = 0;
    while (stamps_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (stamps_q.size() < n) begin
      bad++;
      $display("FAIL %s timeout: pulses %0d expected %0d", what, stamps_q.size(), n);
    end
  endtask

  initial begin
    int base;
    rst_n = 0; btn_next = 0; btn_prev = 0; btn_home = 0; sw_power = 0; sw_auto = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset page", int'(page), 1);
    check("reset ena", int'(ena), 0);
    check("reset pulse", int'(page_pulse), 0);

    // Power up and basic stepping
    sw_power = 1; m_on = 1;
    repeat (12) @(negedge clk);
    check("power ena", int'(ena), 1);
    check("power page", int'(page), 1);
    repeat (3) press(1, 0, 0);
    check("page after 3 next", int'(page), 4);

    // Wrap both ways
    press(1, 0, 0);
    press(1, 0, 0);
    check("wrap up", int'(page), 1);
    press(0, 1, 0);
    check("wrap down", int'(page), NP);

    // Glitch then long hold
    @(negedge clk); btn_next = 1;
    repeat (3) @(negedge clk); btn_next = 0;
    repeat (12) @(negedge clk);
    check("glitch page", int'(page), NP);
    m_press(1, 0, 0);
    btn_next = 1;
    repeat (20) @(negedge clk); btn_next = 0;
    repeat (12) @(negedge clk);
    check("long hold page", int'(page), 1);

    // Auto advance
    press(1, 0, 0);
    base = stamps_q.size();
    @(negedge clk); sw_auto = 1;
    m_set(nxt(m_page));
    m_set(nxt(m_page));
    wait_pulses(base + 2, 200, "auto");
    if (stamps_q.size() >= base + 2)
      check("auto interval", stamps_q[base+1] - stamps_q[base], AC);
    repeat (20) @(negedge clk);
    press(0, 1, 0);
    m_set(nxt(m_page));
    wait_pulses(base + 4, 100, "auto after press");
    if (stamps_q.size() >= base + 4)
      check("press to auto", stamps_q[base+3] - stamps_q[base+2], AC);
    sw_auto = 0;
    repeat (12) @(negedge clk);
    check("auto page", int'(page), 4);

    // Simultaneous presses
    press(1, 1, 0);
    check("next+prev page", int'(page), 4);
    press(1, 0, 1);
    check("home+next page", int'(page), 1);
    press(0, 0, 1);

    // Randomised manual browsing
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 4))
        0: press(1, 0, 0);
        1: press(0, 1, 0);
        2: press(0, 0, 1);
        3: press(1, 1, 0);
        default: press(1, 0, 1);
      endcase
    end
    check("random page", int'(page), m_page);

    // Power off: presses ignored, page held
    sw_power = 0; m_on = 0;
    repeat (12) @(negedge clk);
    check("off ena", int'(ena), 0);
    press(1, 0, 0);
    press(0, 0, 1);
    check("off page held", int'(page), m_page);

    // Back on in AUTO, then reset mid-count
    sw_auto = 1; sw_power = 1;
    repeat (12) @(negedge clk);
    check("auto ena", int'(ena), 1);
    check("page kept over off", int'(page), m_page);
    repeat (10) @(negedge clk);
    rst_n = 0; m_page = 1; m_on = 0;
    #1;
    check("mid-auto reset page", int'(page), 1);
    check("mid-auto reset ena", int'(ena), 0);
    sw_power = 0; sw_auto = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    check("final page", int'(page), 1);
    check("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
